// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired Moore control unit for a single-bus datapath. Each instruction is
// fetched in T0..T2. Its opcode (IR[31:27]) is then executed in T3..T5, plus
// T6 for mul/div. Every output is decoded from registered state only.
//
// Optional feature: define CU_MULDIV_EN to enable mul/div (opcodes 01110/01111)
// and the extra T6 cycle. When it is undefined, those opcodes are illegal.
//
// Ports
//   Clock, Reset_n       : system clock; asynchronous active-low reset
//   IR[31:0]             : instruction register; opcode in IR[31:27]
//   Stop                 : halt request, honoured on the final execute cycle
//   PCout, Zhighout,
//   Zlowout, MDRout      : bus-drive strobes
//   MARin, Zin, PCin,
//   MDRin, IRin, Yin,
//   HIin, LOin           : register-load strobes
//   IncPC, Read          : ALU PC+1 select; memory read into MDR
//   Gra, Grb, Grc,
//   Rin, Rout            : general-register field select and load/drive
//   alu_op[4:0]          : ALU operation (opcode in T4, otherwise 0)
//   Run                  : executing (not RST, not HALT)
//   Illegal              : one-cycle pulse in the T0 after an unsupported opcode
// -----------------------------------------------------------------------------
module control_sequencer (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  alu_op,
    output logic        Run,
    output logic        Illegal
);

    typedef enum logic [3:0] {
        StRst  = 4'd0,
        StT0   = 4'd1,
        StT1   = 4'd2,
        StT2   = 4'd3,
        StT3   = 4'd4,
        StT4   = 4'd5,
        StT5   = 4'd6,
`ifdef CU_MULDIV_EN
        StT6   = 4'd7,
`endif
        StHalt = 4'd8
    } state_e;

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [4:0] opcode;
    logic       is_alu, is_muldiv, is_halt;

    // Only the opcode field is decoded here.
    logic unused_ir;
    assign unused_ir = ^IR[26:0];

    assign opcode  = IR[31:27];
    assign is_alu  = (opcode >= 5'd3) && (opcode <= 5'd11);
    assign is_halt = (opcode == 5'd27);
`ifdef CU_MULDIV_EN
    assign is_muldiv = (opcode == 5'd14) || (opcode == 5'd15);

    // Remembers that the instruction in flight is mul/div, so T5 can pick the
    // LO write-back and continue to T6.
    logic muldiv_q, muldiv_d;
`else
    assign is_muldiv = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= StRst;
            illegal_q <= 1'b0;
`ifdef CU_MULDIV_EN
            muldiv_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
`ifdef CU_MULDIV_EN
            muldiv_q  <= muldiv_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
`ifdef CU_MULDIV_EN
        muldiv_d  = muldiv_q;
`endif
        unique case (state_q)
            StRst: state_d = StT0;
            StT0:  state_d = StT1;
            StT1:  state_d = StT2;
            StT2: begin
                if (is_halt) begin
                    state_d = StHalt;
                end else if (is_alu || is_muldiv) begin
                    state_d = StT3;
`ifdef CU_MULDIV_EN
                    muldiv_d = is_muldiv;
`endif
                end else begin
                    // Skip execution; flag the following T0.
                    state_d   = StT0;
                    illegal_d = 1'b1;
                end
            end
            StT3: state_d = StT4;
            StT4: state_d = StT5;
            StT5: begin
`ifdef CU_MULDIV_EN
                if (muldiv_q) state_d = StT6;
                else          state_d = Stop ? StHalt : StT0;
`else
                state_d = Stop ? StHalt : StT0;
`endif
            end
`ifdef CU_MULDIV_EN
            StT6: state_d = Stop ? StHalt : StT0;
`endif
            StHalt: state_d = StHalt;
            default: state_d = StRst;
        endcase
    end

    // Moore output decode
    always_comb begin
        PCout    = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        Zin      = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        alu_op   = 5'd0;
        Run      = (state_q != StRst) && (state_q != StHalt);
        Illegal  = illegal_q;
        unique case (state_q)
            StT0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            StT1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            StT2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            StT3: begin
                Grb  = 1'b1;
                Rout = 1'b1;
                Yin  = 1'b1;
            end
            StT4: begin
                Grc    = 1'b1;
                Rout   = 1'b1;
                Zin    = 1'b1;
                alu_op = opcode;
            end
            StT5: begin
                Zlowout = 1'b1;
`ifdef CU_MULDIV_EN
                if (muldiv_q) begin
                    LOin = 1'b1;
                end else begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                end
`else
                Gra = 1'b1;
                Rin = 1'b1;
`endif
            end
`ifdef CU_MULDIV_EN
            StT6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Self-checking bench for control_sequencer. A per-instruction model expands
// each opcode into the list of micro-steps it must produce. Each step is
// published as the expected output vector for that cycle, and one compare
// process checks the DUT against it on every falling edge. Directed scenarios
// pin the model with literal expectations; a randomized phase follows them.
// Honours CU_MULDIV_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    typedef struct packed {
        logic       PCout, Zhighout, Zlowout, MDRout;
        logic       MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
        logic       IncPC, Read;
        logic       Gra, Grb, Grc, Rin, Rout;
        logic [4:0] alu_op;
        logic       Run, Illegal;
    } out_t;

    localparam int ClsAlu = 0, ClsMd = 1, ClsHalt = 2, ClsIll = 3;

    logic        Clock, Reset_n, Stop;
    logic [31:0] IR;
    logic        PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
    logic        HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run, Illegal;
    logic [4:0]  alu_op;

    control_sequencer dut (
        .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .Stop(Stop),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .Run(Run), .Illegal(Illegal)
    );

    out_t dut_v;
    assign dut_v = {PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
                    HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op, Run, Illegal};

    int   errors = 0;
    int   checks = 0;
    out_t exp_cur;
    bit   exp_valid = 0;
    bit   pend_illegal = 0;

    initial begin
        Clock = 0;
        forever #5 Clock = ~Clock;
    end

    // Single compare process for the cycle-by-cycle model.
    always @(negedge Clock) begin
        if (exp_valid) begin
            checks++;
            if (dut_v !== exp_cur) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, dut_v, exp_cur);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, req);
        end
    endtask

    function automatic int classify(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd11) return ClsAlu;
        if (op == 5'd27) return ClsHalt;
`ifdef CU_MULDIV_EN
        if (op == 5'd14 || op == 5'd15) return ClsMd;
`endif
        return ClsIll;
    endfunction

    // Stop policy: 0 never, 1 pulse in T3 only, 2 held from T3 on, 3 random.
    function automatic logic stop_for(input int mode, input int stage, input bit fin);
        case (mode)
            1: return stage == 3;
            2: return stage >= 3;
            3: return fin ? ($urandom_range(0, 5) == 0) : logic'($urandom_range(0, 1));
            default: return 1'b0;
        endcase
    endfunction

    // One clock: publish the expectation for the new cycle, then drive the
    // inputs that the cycle's closing edge will sample.
    task automatic step(input out_t e, input logic [31:0] ir_v, input logic stop_v);
        @(posedge Clock);
        #1;
        exp_cur   = e;
        exp_valid = 1;
        IR        = ir_v;
        Stop      = stop_v;
    endtask

    task automatic do_reset();
        exp_valid = 0;
        Reset_n   = 0;
        Stop      = 0;
        #1;
        check("reset_async_zero", 32'(dut_v), 32'h0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        #1;
        check("reset_hold_zero", 32'(dut_v), 32'h0);
        Reset_n      = 1;
        pend_illegal = 0;
    endtask

    task automatic halt_loop(input int n);
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            r = $urandom();
            step(out_t'(0), r, logic'($urandom_range(0, 1)));
        end
        check("halt_run_low", 32'(Run), 32'h0);
    endtask

    // Expands one instruction into its micro-steps.
    task automatic do_instr(input logic [31:0] ir_v, input int smode, input bit abort,
                            output bit halted, output logic cap_illegal,
                            output logic [4:0] cap_alu, output out_t cap_last);
        out_t base, e;
        int   c;
        c       = classify(ir_v[31:27]);
        halted  = 0;
        cap_alu = '0;
        base     = '0;
        base.Run = 1;

        e = base; e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin = 1; e.Illegal = pend_illegal;
        step(e, ir_v, stop_for(smode, 0, 0));
        cap_illegal  = Illegal;
        pend_illegal = 0;

        e = base; e.Zlowout = 1; e.PCin = 1; e.Read = 1; e.MDRin = 1;
        step(e, ir_v, stop_for(smode, 1, 0));

        e = base; e.MDRout = 1; e.IRin = 1;
        step(e, ir_v, stop_for(smode, 2, 0));
        cap_last = dut_v;
        if (c == ClsHalt) begin
            halted = 1;
            return;
        end
        if (c == ClsIll) begin
            pend_illegal = 1;
            return;
        end

        e = base; e.Grb = 1; e.Rout = 1; e.Yin = 1;
        step(e, ir_v, stop_for(smode, 3, 0));

        e = base; e.Grc = 1; e.Rout = 1; e.Zin = 1; e.alu_op = ir_v[31:27];
        step(e, ir_v, stop_for(smode, 4, 0));
        cap_alu = alu_op;
        if (abort) begin
            #5;  // past the falling-edge compare, mid T4
            check("abort_t4_active", 32'({Rout, Run}), 32'h3);
            do_reset();
            return;
        end

        if (c == ClsAlu) begin
            e = base; e.Zlowout = 1; e.Gra = 1; e.Rin = 1;
            step(e, ir_v, stop_for(smode, 5, 1));
        end else begin
            e = base; e.Zlowout = 1; e.LOin = 1;
            step(e, ir_v, stop_for(smode, 5, 0));
            e = base; e.Zhighout = 1; e.HIin = 1;
            step(e, ir_v, stop_for(smode, 6, 1));
        end
        halted   = Stop;
        cap_last = dut_v;
    endtask

    bit          h;
    logic        ci;
    logic [4:0]  ca;
    out_t        cl;
    logic [31:0] r;
    logic [4:0]  op;

    initial begin
        Reset_n = 0;
        IR      = '0;
        Stop    = 0;
        do_reset();

        // shra R1,R2,R3
        do_instr(32'h40918000, 0, 0, h, ci, ca, cl);
        check("shra_t4_alu_op", 32'(ca), 32'h08);
        check("shra_t5_gra_rin_zlow", 32'({cl.Gra, cl.Rin, cl.Zlowout}), 32'h7);
        check("shra_t5_alu_op_zero", 32'(cl.alu_op), 32'h0);
        do_instr(32'h18000000, 0, 0, h, ci, ca, cl);   // add
        check("after_shra_t0_no_illegal", 32'(ci), 32'h0);

        // mul
        do_instr(32'h70000000, 0, 0, h, ci, ca, cl);
`ifdef CU_MULDIV_EN
        check("mul_t6_hi", 32'({cl.Zhighout, cl.HIin, cl.LOin}), 32'h6);
        check("mul_t4_alu_op", 32'(ca), 32'h0e);
`else
        check("mul_last_is_t2", 32'({cl.IRin, cl.Yin, cl.Zin}), 32'h4);
`endif
        do_instr(32'h28000000, 0, 0, h, ci, ca, cl);   // and
`ifdef CU_MULDIV_EN
        check("mul_next_t0_illegal", 32'(ci), 32'h0);
`else
        check("mul_next_t0_illegal", 32'(ci), 32'h1);
`endif

        // Stop pulsed in T3 only: instruction completes and fetch continues
        do_instr(32'h30000000, 1, 0, h, ci, ca, cl);
        check("stop_pulse_t5", 32'({cl.Gra, cl.Rin}), 32'h3);
        do_instr(32'h38000000, 0, 0, h, ci, ca, cl);
        check("stop_pulse_t4_alu_op", 32'(ca), 32'h07);

        // Stop held through T5: HALT follows
        do_instr(32'h20000000, 2, 0, h, ci, ca, cl);
        halt_loop(6);
        do_reset();

        // halt opcode
        do_instr(32'hD8000000, 0, 0, h, ci, ca, cl);
        halt_loop(20);
        do_reset();

        // Reset mid T4, then fetch resumes on the first edge
        do_instr(32'h50000000, 0, 1, h, ci, ca, cl);
        do_instr(32'h58000000, 0, 0, h, ci, ca, cl);
        check("after_abort_rol_alu_op", 32'(ca), 32'h0b);

        // Randomized phase
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 19))
                0:             op = 5'd27;
                1, 2, 3:       op = 5'($urandom_range(14, 15));
                4, 5, 6, 7:    op = 5'($urandom_range(0, 31));
                default:       op = 5'($urandom_range(3, 11));
            endcase
            r        = $urandom();
            r[31:27] = op;
            do_instr(r, 3, ($urandom_range(0, 29) == 0), h, ci, ca, cl);
            if (h) begin
                halt_loop($urandom_range(2, 8));
                do_reset();
            end
        end

        exp_valid = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Clock  input  1  single system clock; all state advances on rising edge.
REQ-002 Reset_n  input  1  asynchronous, active-low reset.
REQ-003 IR  input  32  instruction register contents from datapath; IR[31:27] is the instruction opcode.
REQ-004 Stop  input  1  request to halt after the current instruction completes.
REQ-005 PCout, Zhighout, Zlowout, MDRout  output  1 each  datapath bus-drive strobes.
REQ-006 MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin  output  1 each  datapath register-load strobes.
REQ-007 IncPC  output  1  ALU computes PC+1 in place of the opcode operation.
REQ-008 Read  output  1  memory read enable into MDR.
REQ-009 Gra, Grb, Grc  output  1 each  select IR ra/rb/rc field for the register-select logic.
REQ-010 Rin, Rout  output  1 each  load/drive the register chosen by Gra/Grb/Grc.
REQ-011 alu_op  output  5  ALU operation code to datapath.
REQ-012 Run  output  1  high while the sequencer is executing; low in HALT.
REQ-013 Illegal  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-014 Outputs are Moore, decoded from the current state only; one state per Clock cycle.
REQ-015 States: RST, T0, T1, T2, T3, T4, T5, T6, HALT; 4-bit encoding.
REQ-016 T0: PCout, MARin, IncPC, Zin = 1.
REQ-017 T1: Zlowout, PCin, Read, MDRin = 1.
REQ-018 T2: MDRout, IRin = 1.
REQ-019 Decode at end of T2 on IR[31:27]: ALU class = 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shra, 01001 shl, 01010 ror, 01011 rol; mul = 01110; div = 01111; halt = 11011; all others illegal.
REQ-020 T3 (ALU, mul, div): Grb, Rout, Yin = 1.
REQ-021 T4: Grc, Rout, Zin = 1; alu_op = IR[31:27]; alu_op = 00000 in every other state.
REQ-022 T5 ALU class: Zlowout, Gra, Rin = 1; next state T0.
REQ-023 T5 mul/div: Zlowout, LOin = 1; next state T6; T6: Zhighout, HIin = 1; next state T0.
REQ-024 halt opcode: T2 -> HALT; illegal opcode: T2 -> T0 with Illegal = 1 during the T0 cycle that follows.
REQ-025 Stop sampled only on the final execute cycle (T5 or T6); if 1, next state is HALT instead of T0; Stop at any other time is ignored until then.
REQ-026 HALT: all strobes 0, Run = 0; leaves HALT only through reset.
REQ-027 Run = 1 in every state except HALT and RST.
REQ-028 ALU instruction latency = 6 cycles T0..T5; mul/div = 7 cycles.

Reset
REQ-029 Reset_n = 0 forces state RST immediately, independent of Clock; all outputs 0, including Run and Illegal.
REQ-030 RST -> T0 on the first rising Clock with Reset_n = 1; reset asserted mid-instruction aborts it with no further strobes.

Configuration
REQ-031 Macro CU_MULDIV_EN: when defined, mul/div follow REQ-023; when undefined, opcodes 01110/01111 are treated as illegal per REQ-024 and state T6 is not implemented.

Verification
REQ-032 Release reset, IR = 0x40918000 (shra R1,R2,R3): T0..T5 strobes per REQ-016..022, alu_op = 01000 only in T4, Gra+Rin in T5, back in T0 on cycle 7.
REQ-033 IR = 0x70000000 (mul) with CU_MULDIV_EN: LOin in T5, HIin in T6, T0 on cycle 8; without the macro: Illegal = 1 in the cycle after T2, no Yin/Zin execute strobes.
REQ-034 IR = 0xD8000000 (halt): HALT after T2, Run = 0, all strobes 0 for 20 cycles.
REQ-035 Stop pulsed high in T3 only -> instruction completes and fetch continues; Stop held high through T5 -> HALT follows T5.
REQ-036 Reset_n driven low in the middle of T4 -> all outputs 0 immediately without waiting for Clock; after release, T0 on the first Clock edge.
